subservient_uart_tx: RTL

Wishbone-slave UART transmitter for the Subservient SoC. It is the transmit end of the serial link whose receive end is the bench uart_decoder on io_out. Firmware pushes bytes into a small FIFO. The block serializes them as 8N1 frames, LSB first, at a runtime-programmable baud divisor. It connects to the same wbs_* slave bus style as the debug interface.

---
 rtl/subservient_uart_tx_if.sv | 22 ++
 rtl/subservient_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/subservient_uart_tx_if.sv
// Wishbone slave bus bundle for subservient_uart_tx.
// Signals: wbs_adr_i/wbs_dat_i/wbs_sel_i/wbs_we_i/wbs_stb_i (master -> slave),
//          wbs_dat_o/wbs_ack_o (slave -> master).
interface subservient_uart_tx_if;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o
  );
endinterface

// File: rtl/subservient_uart_tx.sv
// Wishbone-slave UART transmitter: FIFO-buffered 8N1 serializer, LSB first,
// with a runtime-programmable baud divisor.
// Ports:
//   wb_clk_i  - system clock (rising edge)
//   wb_rst_i  - asynchronous active-high reset
//   wbs       - wishbone slave bundle (subservient_uart_tx_if.slave)
//   io_out    - serial TX line, idles high
//   o_busy    - frame in progress or FIFO non-empty
// Registers (adr[3:2]): 0 TXDATA (wo), 1 STATUS, 2 DIV, 3 reserved.
// Optional: define SUBSERVIENT_UART_TX_PARITY_EN for 8E1 frames (even parity
// bit between data and stop; STATUS bit4 reads 1).
module subservient_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = 139
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  subservient_uart_tx_if.slave        wbs,
  output logic                        io_out,
  output logic                        o_busy
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = 16;
`ifdef SUBSERVIENT_UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] level_q;
  logic [DIV_W-1:0] div_q, baud_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_q;
  logic             ovf_q, ack_q, io_q;
  logic [31:0]      dat_q;
`ifdef SUBSERVIENT_UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic             access, is_wr, full, empty, bit_end, pop, push_req, push;
  logic [1:0]       reg_sel;
  logic [DIV_W-1:0] reload_d;
  logic [31:0]      rdata;
  logic             unused_bits;

  // One access per stb assertion: the edge that raises ack
  assign access   = wbs.wbs_stb_i & ~ack_q;
  assign is_wr    = access & wbs.wbs_we_i;
  assign reg_sel  = wbs.wbs_adr_i[3:2];
  assign full     = (level_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign bit_end  = (baud_q == '0);
  // Effective divisor is max(DIV,1); counter counts D-1 down to 0
  assign reload_d = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  // Pop from idle, or at the end of the stop bit for zero-gap back-to-back frames
  assign pop      = ~empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign push_req = is_wr & (reg_sel == 2'd0) & wbs.wbs_sel_i[0];
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands
  assign push     = push_req & (~full | pop);

  assign unused_bits = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                         wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

  // Register read mux
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd1: begin
        rdata[0]    = full;
        rdata[1]    = empty;
        rdata[2]    = (state_q != IDLE);
        rdata[3]    = ovf_q;
        rdata[4]    = PAR_EN;
        rdata[11:8] = 4'(level_q);
      end
      2'd2:    rdata[15:0] = div_q;
      default: rdata = '0;
    endcase
  end

  // FIFO storage (no reset needed; validity tracked by level_q)
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wbs.wbs_dat_i[7:0];
  end

  // Bus, registers, FIFO pointers and TX FSM
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      baud_q   <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      io_q     <= 1'b1;
      dat_q    <= '0;
`ifdef SUBSERVIENT_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      ack_q <= access;
      dat_q <= (access & ~wbs.wbs_we_i) ? rdata : '0;

      if (is_wr && reg_sel == 2'd2) begin
        if (wbs.wbs_sel_i[0]) div_q[7:0]  <= wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) div_q[15:8] <= wbs.wbs_dat_i[15:8];
      end

      // Overflow set takes priority over a same-edge clear
      if (push_req && !push) begin
        ovf_q <= 1'b1;
      end else if (is_wr && reg_sel == 2'd1 && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[3]) begin
        ovf_q <= 1'b0;
      end

      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + CNT_W'(1);
      else if (pop && !push) level_q <= level_q - CNT_W'(1);

      if (pop) begin
        shift_q <= mem_q[rd_ptr_q];
        io_q    <= 1'b0;
        baud_q  <= reload_d;
        state_q <= START;
`ifdef SUBSERVIENT_UART_TX_PARITY_EN
        par_q   <= ^mem_q[rd_ptr_q];
`endif
      end else begin
        case (state_q)
          IDLE: io_q <= 1'b1;
          START: begin
            if (bit_end) begin
              io_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= '0;
              baud_q  <= reload_d;
              state_q <= DATA;
            end else begin
              baud_q <= baud_q - DIV_W'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_q <= reload_d;
              if (bit_q == 3'd7) begin
`ifdef SUBSERVIENT_UART_TX_PARITY_EN
                io_q    <= par_q;
                state_q <= PARITY;
`else
                io_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                io_q    <= shift_q[0];
                shift_q <= shift_q >> 1;
                bit_q   <= bit_q + 3'd1;
              end
            end else begin
              baud_q <= baud_q - DIV_W'(1);
            end
          end
          PARITY: begin
            if (bit_end) begin
              io_q    <= 1'b1;
              baud_q  <= reload_d;
              state_q <= STOP;
            end else begin
              baud_q <= baud_q - DIV_W'(1);
            end
          end
          STOP: begin
            // Stop end with an empty FIFO; the non-empty case is the pop branch
            if (bit_end) state_q <= IDLE;
            else         baud_q  <= baud_q - DIV_W'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign io_out        = io_q;
  assign o_busy        = (state_q != IDLE) | ~empty;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
endmodule
